// File: rtl/i2s_dac_tx.sv
// I2S DAC transmitter: 16-bit stereo in SLOT_BITS-wide slots, fed from a
// one-deep holding buffer; silence plus an underrun pulse when it runs dry.
module i2s_dac_tx #(
  parameter int BCLK_DIV  = 16,
  parameter int SLOT_BITS = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] mix_down,
  input  logic        sample_valid,
  output logic        sample_ready,
  output logic        aud_bclk,
  output logic        aud_daclrck,
  output logic        aud_dacdat,
  output logic        frame_tick,
  output logic        underrun
);
  localparam int DW = $clog2(BCLK_DIV);
  localparam int CW = $clog2(2 * SLOT_BITS);
  localparam logic [DW-1:0] DIV_MAX = DW'(BCLK_DIV - 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(2 * SLOT_BITS - 1);
  localparam logic [CW-1:0] SLOT    = CW'(SLOT_BITS);
  localparam logic [CW-1:0] MSB_POS = CW'(16);

  logic [DW-1:0] div_cnt;
  logic [CW-1:0] bit_cnt;
  logic [31:0]   hold;
  logic [31:0]   frame;
  logic          full;
  logic          fall;
  logic          load;
  logic          accept;
  logic [CW-1:0] nxt_cnt;
  logic [CW-1:0] pos;
  logic          nxt_lr;
  logic          nxt_dat;
  logic [15:0]   chan;
  logic [3:0]    idx;

  assign sample_ready = ~full;
  assign accept       = sample_valid & ~full;
  assign fall         = (div_cnt == DIV_MAX) & aud_bclk;
  assign load         = fall & (bit_cnt == CNT_MAX);

  // Pin values for the bit period that starts at the next falling toggle
  always_comb begin
    nxt_cnt = (bit_cnt == CNT_MAX) ? '0 : bit_cnt + 1'b1;
    nxt_lr  = nxt_cnt >= SLOT;
    pos     = nxt_lr ? nxt_cnt - SLOT : nxt_cnt;
    chan    = nxt_lr ? frame[15:0] : frame[31:16];
    idx     = 4'(MSB_POS - pos);
    nxt_dat = 1'b0;
    if (pos != '0 && pos <= MSB_POS) nxt_dat = chan[idx];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_cnt  <= '0;
      aud_bclk <= 1'b0;
    end else if (div_cnt == DIV_MAX) begin
      div_cnt  <= '0;
      aud_bclk <= ~aud_bclk;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bit_cnt     <= '0;
      aud_daclrck <= 1'b0;
      aud_dacdat  <= 1'b0;
    end else if (fall) begin
      bit_cnt     <= nxt_cnt;
      aud_daclrck <= nxt_lr;
      aud_dacdat  <= nxt_dat;
    end
  end

  // Load sees the buffer state before any same-cycle accept
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hold       <= '0;
      full       <= 1'b0;
      frame      <= '0;
      frame_tick <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      frame_tick <= load;
      underrun   <= load & ~full;
      full       <= accept | (full & ~load);
      if (load) frame <= full ? hold : '0;
      if (accept) hold <= mix_down;
    end
  end

endmodule
